// File: rtl/ballot_input_ctrl_if.sv
// Ballot front-end bus: officer arm level, raw buttons in, tally-side strobes out.
interface ballot_input_ctrl_if;
    logic officer_en;
    logic btn_a;
    logic btn_b;
    logic btn_c;
    logic btn_cast;
    logic vote_a;
    logic vote_b;
    logic vote_c;
    logic vote_strobe;
    logic session_active;
    logic invalid;
    logic timeout;

    // Drives the officer level and raw buttons (testbench / panel side).
    modport master (
        output officer_en, btn_a, btn_b, btn_c, btn_cast,
        input  vote_a, vote_b, vote_c, vote_strobe, session_active, invalid, timeout
    );

    // The ballot controller itself.
    modport slave (
        input  officer_en, btn_a, btn_b, btn_c, btn_cast,
        output vote_a, vote_b, vote_c, vote_strobe, session_active, invalid, timeout
    );
endinterface

// File: rtl/ballot_input_ctrl.sv
// Ballot input controller: synchronises and debounces the candidate and cast
// buttons, enforces one vote per officer-armed session and emits a one-hot
// candidate select qualified by a single-cycle cast strobe for the tally.
module ballot_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic          clk,
    input  logic          rst,
    ballot_input_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ARMED, SELECTED, CAST, RELEASE} state_t;

    // Button vector order: {cast, c, b, a}
    logic [3:0]         raw;
    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         deb_q, deb_prev_q;
    logic [3:0][DW-1:0] dcnt_q;
    logic [3:0]         rise;
    logic [2:0]         cand_lvl;
    logic               cand_rise;
    logic               cand_single;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic [TW-1:0]      tcnt_q;
    logic               off_q;
    logic               off_rise;
    logic [2:0]         vote_q;
    logic               strobe_q;
    logic               active_q;
    logic               invalid_q;
    logic               timeout_q;

    assign raw         = {bus.btn_cast, bus.btn_c, bus.btn_b, bus.btn_a};
    assign rise        = deb_q & ~deb_prev_q;
    assign cand_lvl    = deb_q[2:0];
    assign cand_rise   = |rise[2:0];
    // The rising candidate is itself high, so a valid press means it is the only one high.
    assign cand_single = $onehot(cand_lvl);
    assign off_rise    = bus.officer_en & ~off_q;

    // Two-flop synchronisers for the asynchronous buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: adopt the synced level after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '0;
        end else begin
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i]  <= sync2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Session FSM with registered outputs; the cast pulse is decided on the same edge that enters CAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            tcnt_q    <= '0;
            off_q     <= 1'b0;
            vote_q    <= '0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
            invalid_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            off_q     <= bus.officer_en;
            vote_q    <= '0;
            strobe_q  <= 1'b0;
            invalid_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (off_rise) begin
                        state_q  <= ARMED;
                        sel_q    <= '0;
                        tcnt_q   <= '0;
                        active_q <= 1'b1;
                    end
                end
                ARMED, SELECTED: begin
                    // Cast has priority over a same-cycle candidate press.
                    if (rise[3]) begin
                        if (state_q == SELECTED) begin
                            state_q  <= CAST;
                            strobe_q <= 1'b1;
                            vote_q   <= sel_q;
                        end else begin
                            invalid_q <= 1'b1;
                        end
                    end else if (cand_rise) begin
                        if (cand_single) begin
                            sel_q   <= cand_lvl;
                            state_q <= SELECTED;
                        end else begin
                            invalid_q <= 1'b1;
                        end
                    end
                    // Inactivity timer: any debounced press restarts it.
                    if (|rise) begin
                        tcnt_q <= '0;
                    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        sel_q     <= '0;
                        active_q  <= 1'b0;
                        tcnt_q    <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                CAST: begin
                    state_q  <= RELEASE;
                    sel_q    <= '0;
                    active_q <= 1'b0;
                end
                RELEASE: begin
                    if (deb_q == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vote_a         = vote_q[0];
    assign bus.vote_b         = vote_q[1];
    assign bus.vote_c         = vote_q[2];
    assign bus.vote_strobe    = strobe_q;
    assign bus.session_active = active_q;
    assign bus.invalid        = invalid_q;
    assign bus.timeout        = timeout_q;
endmodule

// File: tb/tb_ballot_input_ctrl.sv
// Bench for ballot_input_ctrl: directed session scenarios followed by random
// button/officer activity, all compared cycle by cycle with a behavioural model.
module tb_ballot_input_ctrl;
    localparam int DEB = 4;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ballot_input_ctrl_if bus();

    ballot_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: raw sample history, debounced levels and session facts.
    logic [3:0] rh [0:DEB];  // rh[i] = raw {cast,c,b,a} sampled i+1 edges ago
    logic [3:0] m_deb, m_deb_prev;
    logic       m_off_prev;
    bit         m_sess, m_hassel, m_cast, m_rel;
    logic [2:0] m_sel;
    int         m_idle;
    logic [6:0] m_exp;  // {active, invalid, timeout, strobe, c, b, a}

    int n_strobe, n_inv, n_to;
    logic [2:0] last_vote;

    function automatic logic [6:0] outv();
        return {bus.session_active, bus.invalid, bus.timeout, bus.vote_strobe,
                bus.vote_c, bus.vote_b, bus.vote_a};
    endfunction

    task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DEB; i++) rh[i] = '0;
        m_deb = '0; m_deb_prev = '0; m_off_prev = 1'b0;
        m_sess = 0; m_hassel = 0; m_cast = 0; m_rel = 0;
        m_sel = '0; m_idle = 0; m_exp = '0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_edge();
        logic [3:0] raw, lev, rise, nd;
        logic       ofr, strobe, inv, to;
        logic [2:0] vote;
        bit         all_diff;
        raw  = {bus.btn_cast, bus.btn_c, bus.btn_b, bus.btn_a};
        lev  = m_deb;
        rise = m_deb & ~m_deb_prev;
        ofr  = bus.officer_en & ~m_off_prev;
        // Synced copy lags raw by two edges; flip once the last DEB synced samples all disagree.
        nd = m_deb;
        for (int b = 0; b < 4; b++) begin
            all_diff = 1;
            for (int j = 1; j <= DEB; j++) if (rh[j][b] == m_deb[b]) all_diff = 0;
            if (all_diff) nd[b] = ~m_deb[b];
        end
        for (int i = DEB; i > 0; i--) rh[i] = rh[i-1];
        rh[0] = raw;
        m_deb_prev = m_deb;
        m_deb      = nd;
        m_off_prev = bus.officer_en;

        strobe = 0; inv = 0; to = 0; vote = '0;
        if (m_cast) begin
            m_cast = 0; m_rel = 1;
        end else if (m_rel) begin
            if (lev == '0) m_rel = 0;
        end else if (!m_sess) begin
            if (ofr) begin m_sess = 1; m_hassel = 0; m_idle = 0; end
        end else begin
            if (rise[3]) begin
                if (m_hassel) begin
                    strobe = 1; vote = m_sel; m_sess = 0; m_hassel = 0; m_cast = 1;
                end else inv = 1;
            end else if (|rise[2:0]) begin
                if ($countones(lev[2:0]) == 1) begin m_sel = lev[2:0]; m_hassel = 1; end
                else inv = 1;
            end
            if (m_sess) begin
                if (|rise) m_idle = 0;
                else if (m_idle == TO - 1) begin to = 1; m_sess = 0; m_hassel = 0; end
                else m_idle++;
            end
        end
        m_exp = {m_sess | m_cast, inv, to, strobe, vote};
    endtask

    task automatic step(string tag = "cycle");
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, outv(), m_exp);
        n_strobe += int'(bus.vote_strobe);
        n_inv    += int'(bus.invalid);
        n_to     += int'(bus.timeout);
        if (bus.vote_strobe) last_vote = {bus.vote_c, bus.vote_b, bus.vote_a};
    endtask

    task automatic hold(int n);
        repeat (n) step();
    endtask

    task automatic btn(logic [3:0] m);
        {bus.btn_cast, bus.btn_c, bus.btn_b, bus.btn_a} = m;
    endtask

    task automatic clr();
        n_strobe = 0; n_inv = 0; n_to = 0; last_vote = '0;
    endtask

    task automatic arm();
        bus.officer_en = 1'b0; hold(2);
        bus.officer_en = 1'b1; hold(3);
    endtask

    task automatic press(logic [3:0] m, int on, int off);
        btn(m); hold(on);
        btn(4'b0000); hold(off);
    endtask

    initial begin
        int n;
        logic [6:0] pre;
        rst = 1'b1;
        bus.officer_en = 1'b0;
        btn(4'b0000);
        clr();
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk("reset_state", outv(), 7'b0);
        @(negedge clk) rst = 1'b0;

        // 1: clean B then cast; strobe lands 2 sync + DEB debounce + 1 cycles after raw cast.
        arm();
        press(4'b0010, 10, 10);
        clr();
        btn(4'b1000);
        n = 0;
        while (!bus.vote_strobe && n < 40) begin step("t1_cast"); n++; end
        chk_i("t1_cast_latency", n, 2 + DEB + 1);
        hold(10);
        btn(4'b0000); hold(15);
        chk_i("t1_strobes", n_strobe, 1);
        chk_i("t1_vote", int'(last_vote), 2);

        // 2: A bounces every 2 clk for 20 clk (never stable DEB cycles) then held.
        arm();
        clr();
        for (int i = 0; i < 10; i++) begin btn((i % 2 == 0) ? 4'b0001 : 4'b0000); hold(2); end
        chk_i("t2_no_invalid_during_bounce", n_inv, 0);
        press(4'b0001, 10, 10);
        press(4'b1000, 10, 15);
        chk_i("t2_strobes", n_strobe, 1);
        chk_i("t2_vote", int'(last_vote), 1);

        // 3: A then C replaces selection; cast in a fresh session without selection is rejected.
        arm();
        clr();
        press(4'b0001, 10, 10);
        press(4'b0100, 10, 10);
        press(4'b1000, 10, 15);
        chk_i("t3_strobes", n_strobe, 1);
        chk_i("t3_vote", int'(last_vote), 4);
        arm();
        clr();
        press(4'b1000, 10, 15);
        chk_i("t3_cast_nosel_invalid", n_inv, 1);
        chk_i("t3_cast_nosel_strobe", n_strobe, 0);
        hold(60);
        chk_i("t3_timeout", n_to, 1);

        // 4: A and B together -> invalid, session stays armed.
        arm();
        clr();
        press(4'b0011, 10, 10);
        chk_i("t4_invalid", n_inv, 1);
        chk_i("t4_strobe", n_strobe, 0);
        chk_i("t4_active", int'(bus.session_active), 1);
        hold(60);

        // 5: no input for TO cycles after arming -> timeout; later cast is ignored silently.
        bus.officer_en = 1'b0; hold(2);
        clr();
        bus.officer_en = 1'b1;
        n = 0;
        while (!bus.timeout && n < 200) begin step("t5_wait"); n++; end
        chk_i("t5_timeout_cycle", n, TO + 1);
        chk_i("t5_inactive", int'(bus.session_active), 0);
        clr();
        press(4'b1000, 10, 15);
        chk_i("t5_cast_strobe", n_strobe, 0);
        chk_i("t5_cast_invalid", n_inv, 0);

        // 6: one strobe per session even with repeated cast; reset mid-session clears outputs.
        arm();
        clr();
        press(4'b0010, 10, 10);
        press(4'b1000, 20, 10);
        press(4'b1000, 10, 15);
        chk_i("t6_strobes", n_strobe, 1);
        chk_i("t6_invalid", n_inv, 0);
        arm();
        press(4'b0001, 10, 5);
        pre = outv();
        chk_i("t6_active_before_rst", int'(pre[6]), 1);
        #2 rst = 1'b1;
        #1 chk("t6_rst_async", outv(), 7'b0);
        btn(4'b0000);
        bus.officer_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hold(3);

        // Random activity: bouncing buttons, random officer edges.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] b;
            b = {bus.btn_cast, bus.btn_c, bus.btn_b, bus.btn_a};
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 9) == 0) b[k] = ~b[k];
            btn(b);
            if ($urandom_range(0, 29) == 0) bus.officer_en = ~bus.officer_en;
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
